can_frame_tx: RTL and testbench



---
 rtl/can_pkg.sv | 30 +++
 rtl/can_frame_tx_if.sv | 27 ++
 rtl/can_crc15.sv | 28 ++
 rtl/can_frame_tx.sv | 192 +++++++++++++++++++
 tb/tb_can_frame_tx.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/can_pkg.sv
// Shared CAN definitions used by the transmitter and the bit-level receiver.
package can_pkg;

  localparam logic [14:0] CAN_CRC_POLY    = 15'h4599;
  localparam int          CAN_STUFF_LIMIT = 5;
  localparam int          CAN_EOF_BITS    = 7;
  localparam int          CAN_IFS_BITS    = 3;
  localparam int          CAN_ID_BITS     = 11;
  localparam int          CAN_CTRL_BITS   = 6;   // IDE, r0, DLC[3:0]
  localparam int          CAN_CRC_BITS    = 15;
  localparam int          CAN_TAIL_BITS   = 3 + CAN_EOF_BITS;  // CRC delim, ACK, ACK delim, EOF

  // Frame-field states; the receiver walks the same field sequence.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SOF  = 3'd1,
    ST_ARB  = 3'd2,
    ST_CTRL = 3'd3,
    ST_DATA = 3'd4,
    ST_CRC  = 3'd5,
    ST_TAIL = 3'd6,
    ST_IFS  = 3'd7
  } can_state_e;

  // Number of payload bits carried for a given DLC (DLC above 8 still means 8 bytes).
  function automatic logic [6:0] can_data_bits(input logic [3:0] dlc);
    return (dlc > 4'd8) ? 7'd64 : {dlc, 3'b000};
  endfunction

endpackage

// File: rtl/can_frame_tx_if.sv
// Message-buffer side of the CAN transmitter plus its serial outputs.
interface can_frame_tx_if;
  import can_pkg::*;

  // Handshake: i_Tx_DV is a valid strobe with an implicit ready equal to
  // !o_Tx_Active. A request is accepted on any clock where DV=1 and the
  // transmitter is idle (including the cycle carrying o_Tx_Done); while
  // o_Tx_Active is high DV and the payload inputs are ignored.
  logic        i_Tx_DV;
  logic [10:0] i_Tx_Id;
  logic [3:0]  i_Tx_Dlc;
  logic [63:0] i_Tx_Data;
  logic        o_Tx_Serial;
  logic        o_Tx_Active;
  logic        o_Tx_Done;
  can_state_e  dbg_state;

  modport master (
    output i_Tx_DV, i_Tx_Id, i_Tx_Dlc, i_Tx_Data,
    input  o_Tx_Serial, o_Tx_Active, o_Tx_Done, dbg_state
  );

  modport slave (
    input  i_Tx_DV, i_Tx_Id, i_Tx_Dlc, i_Tx_Data,
    output o_Tx_Serial, o_Tx_Active, o_Tx_Done, dbg_state
  );
endinterface

// File: rtl/can_crc15.sv
// Serial CAN CRC-15: one frame bit per enable, init value 0.
module can_crc15
  import can_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        enable,
  input  logic        data_bit,
  output logic [14:0] crc
);

  logic [14:0] crc_q;

  // Shift-and-conditionally-XOR step; clear has priority over enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q <= '0;
    end else if (clear) begin
      crc_q <= '0;
    end else if (enable) begin
      crc_q <= {crc_q[13:0], 1'b0} ^ ((data_bit ^ crc_q[14]) ? CAN_CRC_POLY : 15'h0000);
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/can_frame_tx.sv
// CAN 2.0A standard data frame transmitter: framing, CRC-15, bit stuffing
// and bit timing. The line bit is decoded from registered state so an
// asynchronous reset forces the bus recessive immediately.
module can_frame_tx
  import can_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input logic           i_Clock,
  input logic           i_Reset,
  can_frame_tx_if.slave tx
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  can_state_e     state_q, state_d;
  logic [6:0]     bit_idx_q, bit_idx_d;
  logic [CW-1:0]  clk_cnt_q, clk_cnt_d;
  logic [2:0]     run_len_q, run_len_d;
  logic           last_bit_q, last_bit_d;
  logic           stuff_q, stuff_d;
  logic           done_q, done_d;
  logic [10:0]    id_q;
  logic [3:0]     dlc_q;
  logic [63:0]    data_q;

  logic           capture;
  logic           crc_clr;
  logic           crc_en;
  logic [14:0]    crc_val;
  logic           frame_bit;
  logic           line_bit;
  logic [6:0]     field_len;
  logic           in_stuff_region;
  logic [11:0]    arb_vec;
  logic [5:0]     ctrl_vec;
  logic [6:0]     data_bits;

  assign arb_vec   = {id_q, 1'b0};          // ID then RTR=0
  assign ctrl_vec  = {2'b00, dlc_q};        // IDE=0, r0=0, DLC
  assign data_bits = can_data_bits(dlc_q);

  can_crc15 u_crc (
    .clk      (i_Clock),
    .rst      (i_Reset),
    .clear    (crc_clr),
    .enable   (crc_en),
    .data_bit (line_bit),
    .crc      (crc_val)
  );

  // Decode the unstuffed frame bit and field length for the current field.
  always_comb begin
    frame_bit       = 1'b1;
    field_len       = 7'd1;
    in_stuff_region = 1'b0;
    case (state_q)
      ST_SOF: begin
        frame_bit       = 1'b0;
        field_len       = 7'd1;
        in_stuff_region = 1'b1;
      end
      ST_ARB: begin
        frame_bit       = arb_vec[4'd11 - bit_idx_q[3:0]];
        field_len       = 7'(CAN_ID_BITS + 1);
        in_stuff_region = 1'b1;
      end
      ST_CTRL: begin
        frame_bit       = ctrl_vec[3'd5 - bit_idx_q[2:0]];
        field_len       = 7'(CAN_CTRL_BITS);
        in_stuff_region = 1'b1;
      end
      ST_DATA: begin
        frame_bit       = data_q[6'd63 - bit_idx_q[5:0]];
        field_len       = data_bits;
        in_stuff_region = 1'b1;
      end
      ST_CRC: begin
        frame_bit       = crc_val[4'd14 - bit_idx_q[3:0]];
        field_len       = 7'(CAN_CRC_BITS);
        in_stuff_region = 1'b1;
      end
      ST_TAIL: field_len = 7'(CAN_TAIL_BITS);
      ST_IFS:  field_len = 7'(CAN_IFS_BITS);
      default: field_len = 7'd1;
    endcase
  end

  // A pending stuff bit overrides the field bit and is the complement of the run.
  assign line_bit = (state_q == ST_IDLE) ? 1'b1 : (stuff_q ? ~last_bit_q : frame_bit);

  // Next-state: bit timing, stuff tracking, field walk and completion pulse.
  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    clk_cnt_d  = clk_cnt_q;
    run_len_d  = run_len_q;
    last_bit_d = last_bit_q;
    stuff_d    = stuff_q;
    done_d     = 1'b0;
    capture    = 1'b0;
    crc_clr    = 1'b0;
    crc_en     = 1'b0;
    if (state_q == ST_IDLE) begin
      clk_cnt_d = '0;
      if (tx.i_Tx_DV) begin
        capture    = 1'b1;
        crc_clr    = 1'b1;
        state_d    = ST_SOF;
        bit_idx_d  = '0;
        run_len_d  = '0;
        last_bit_d = 1'b1;
        stuff_d    = 1'b0;
      end
    end else if (clk_cnt_q != CNT_MAX) begin
      clk_cnt_d = clk_cnt_q + 1'b1;
    end else begin
      clk_cnt_d = '0;
      if (stuff_q) begin
        // Stuff bit finished: it starts a new run; the field counter stays put.
        stuff_d    = 1'b0;
        run_len_d  = 3'd1;
        last_bit_d = line_bit;
      end else begin
        if (in_stuff_region) begin
          run_len_d  = (line_bit == last_bit_q) ? run_len_q + 3'd1 : 3'd1;
          last_bit_d = line_bit;
          stuff_d    = (run_len_d == 3'(CAN_STUFF_LIMIT));
          crc_en     = (state_q != ST_CRC);
        end
        if (bit_idx_q == field_len - 7'd1) begin
          bit_idx_d = '0;
          case (state_q)
            ST_SOF:  state_d = ST_ARB;
            ST_ARB:  state_d = ST_CTRL;
            ST_CTRL: state_d = (data_bits == 7'd0) ? ST_CRC : ST_DATA;
            ST_DATA: state_d = ST_CRC;
            ST_CRC:  state_d = ST_TAIL;
            ST_TAIL: state_d = ST_IFS;
            default: begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          endcase
        end else begin
          bit_idx_d = bit_idx_q + 7'd1;
        end
      end
    end
  end

  // State and bit-timing registers.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q    <= ST_IDLE;
      bit_idx_q  <= '0;
      clk_cnt_q  <= '0;
      run_len_q  <= '0;
      last_bit_q <= 1'b1;
      stuff_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      clk_cnt_q  <= clk_cnt_d;
      run_len_q  <= run_len_d;
      last_bit_q <= last_bit_d;
      stuff_q    <= stuff_d;
      done_q     <= done_d;
    end
  end

  // Frame contents are latched at acceptance so the source may move on.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      id_q   <= '0;
      dlc_q  <= '0;
      data_q <= '0;
    end else if (capture) begin
      id_q   <= tx.i_Tx_Id;
      dlc_q  <= tx.i_Tx_Dlc;
      data_q <= tx.i_Tx_Data;
    end
  end

  assign tx.o_Tx_Serial = line_bit;
  assign tx.o_Tx_Active = (state_q != ST_IDLE);
  assign tx.o_Tx_Done   = done_q;
  assign tx.dbg_state   = state_q;

endmodule

// File: tb/tb_can_frame_tx.sv
// Self-checking bench for can_frame_tx: reference frame builder, bit-centre
// monitor with an expected-bit queue, directed and random frames.
module tb_can_frame_tx;
  import can_pkg::*;

  localparam int CPB     = 10;
  localparam int W       = 1;
  localparam int TIMEOUT = 3000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  can_frame_tx_if tx();

  can_frame_tx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .tx      (tx)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           len_q[$];
  logic         cap_q[$];
  logic         ds_q[$];
  int           n_checks = 0;
  int           n_errors = 0;
  int           last_frame_cycles = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Builds the bus image of a frame from the protocol rules: field list,
  // CRC as the remainder of M(x)*x^15 divided by the generator, then stuffing.
  function automatic void push_frame(input logic [10:0] id, input logic [3:0] dlc,
                                     input logic [63:0] data);
    logic raw[$];
    logic [15:0] rem;
    logic [14:0] crc;
    int nbytes, run, total;
    logic last, b;
    raw.push_back(1'b0);
    for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
    raw.push_back(1'b0); raw.push_back(1'b0); raw.push_back(1'b0);
    for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
    nbytes = (dlc > 4'd8) ? 8 : int'(dlc);
    for (int i = 0; i < nbytes * 8; i++) raw.push_back(data[63 - i]);
    rem = 16'h0;
    for (int i = 0; i < raw.size() + 15; i++) begin
      b   = (i < raw.size()) ? raw[i] : 1'b0;
      rem = {rem[14:0], b};
      if (rem[15]) rem = rem ^ 16'hC599;
    end
    crc = rem[14:0];
    for (int i = 14; i >= 0; i--) raw.push_back(crc[i]);
    total = 0; run = 0; last = 1'b1;
    foreach (raw[i]) begin
      exp_q.push_back(raw[i]); total++;
      run  = (raw[i] == last) ? run + 1 : 1;
      last = raw[i];
      if (run == 5) begin
        exp_q.push_back(~last); total++;
        last = ~last; run = 1;
      end
    end
    for (int i = 0; i < 13; i++) begin
      exp_q.push_back(1'b1); total++;
    end
    len_q.push_back(total);
  endfunction

  // Remove stuff bits from the first 'region' captured bits into ds_q.
  function automatic void destuff(input int region);
    int run; logic last; logic skip; logic b;
    ds_q.delete(); run = 0; last = 1'b1; skip = 1'b0;
    for (int i = 0; i < region; i++) begin
      b = cap_q[i];
      if (skip) begin
        skip = 1'b0; run = 1; last = b;
      end else begin
        ds_q.push_back(b);
        run  = (b == last) ? run + 1 : 1;
        last = b;
        if (run == 5) skip = 1'b1;
      end
    end
  endfunction

  function automatic int max_run(input int region);
    int run, best; logic last;
    run = 0; best = 0; last = 1'b1;
    for (int i = 0; i < region; i++) begin
      run  = (i > 0 && cap_q[i] == last) ? run + 1 : 1;
      last = cap_q[i];
      if (run > best) best = run;
    end
    return best;
  endfunction

  // ---------------- monitor ----------------
  logic prev_active = 1'b0;
  logic in_frame    = 1'b0;
  int   cyc         = 0;
  int   cur_len     = 0;
  logic [W-1:0] want_bit;

  always @(negedge clk) begin
    if (rst) begin
      prev_active = 1'b0;
      in_frame    = 1'b0;
    end else begin
      if (tx.o_Tx_Active && !prev_active) begin
        in_frame = 1'b1; cyc = 0; cap_q.delete();
        if (len_q.size() == 0) begin
          chk("unexpected_frame", 64'd1, 64'd0);
          cur_len = 0;
        end else begin
          cur_len = len_q.pop_front();
        end
      end
      if (tx.o_Tx_Active && in_frame) begin
        if (cyc % CPB == CPB / 2) begin
          cap_q.push_back(tx.o_Tx_Serial);
          if (exp_q.size() == 0) begin
            chk("extra_bit", 64'd1, 64'd0);
          end else begin
            want_bit = exp_q.pop_front();
            chk($sformatf("line_bit[%0d]", cyc / CPB), 64'(tx.o_Tx_Serial), 64'(want_bit));
          end
        end
        cyc++;
      end
      if (!tx.o_Tx_Active && prev_active && in_frame) begin
        chk("frame_clocks", 64'(cyc), 64'(cur_len * CPB));
        chk("done_at_end", 64'(tx.o_Tx_Done), 64'd1);
        chk("idle_line", 64'(tx.o_Tx_Serial), 64'd1);
        last_frame_cycles = cyc;
        in_frame = 1'b0;
      end else if (tx.o_Tx_Done) begin
        chk("spurious_done", 64'd1, 64'd0);
      end
      prev_active = tx.o_Tx_Active;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      if (!tx.o_Tx_Active) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("timeout_idle", 64'd1, 64'd0);
  endtask

  task automatic wait_done();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      if (tx.o_Tx_Done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("timeout_done", 64'd1, 64'd0);
    #1;
  endtask

  task automatic drive(input logic [10:0] id, input logic [3:0] dlc, input logic [63:0] data);
    tx.i_Tx_Id   = id;
    tx.i_Tx_Dlc  = dlc;
    tx.i_Tx_Data = data;
    tx.i_Tx_DV   = 1'b1;
  endtask

  task automatic send_frame(input logic [10:0] id, input logic [3:0] dlc, input logic [63:0] data);
    wait_idle();
    drive(id, dlc, data);
    push_frame(id, dlc, data);
    @(negedge clk);
    tx.i_Tx_DV = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  localparam logic [63:0] PAYLOAD = 64'h0123_4567_89AB_CDEF;
  logic [21:0] exp22;
  logic [21:0] got22;
  logic [3:0]  got_dlc;
  logic        ok;

  initial begin
    tx.i_Tx_DV = 1'b0; tx.i_Tx_Id = '0; tx.i_Tx_Dlc = '0; tx.i_Tx_Data = '0;
    #1;
    chk("reset_serial", 64'(tx.o_Tx_Serial), 64'd1);
    chk("reset_active", 64'(tx.o_Tx_Active), 64'd0);
    chk("reset_done",   64'(tx.o_Tx_Done),   64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // All-zero frame: CRC 0, six stuff bits, 50 bits to end of EOF.
    send_frame(11'h000, 4'd0, 64'h0);
    wait_done();
    chk("id0_stuff_bits", 64'(cap_q.size() - 13 - 34), 64'd6);
    chk("id0_sof_to_eof_clocks", 64'((cap_q.size() - 3) * CPB), 64'd500);
    chk("id0_active_clocks", 64'(last_frame_cycles), 64'd530);

    // All-ones ID: stuffing pattern at the start of the frame.
    send_frame(11'h7FF, 4'd0, 64'h0);
    wait_done();
    exp22 = 22'b0111110111110100000100;
    for (int i = 0; i < 22; i++) got22[21 - i] = cap_q[i];
    chk("id7ff_first22", 64'(got22), 64'(exp22));

    // Full 8-byte frame.
    send_frame(11'h123, 4'd8, PAYLOAD);
    wait_done();
    destuff(cap_q.size() - 13);
    chk("dlc8_destuffed_len", 64'(ds_q.size()), 64'd98);
    chk("dlc8_max_run_le5", 64'(max_run(cap_q.size() - 13) <= 5), 64'd1);

    // DLC above 8: field sent verbatim, payload capped at 8 bytes.
    send_frame(11'h123, 4'd12, PAYLOAD);
    wait_done();
    destuff(cap_q.size() - 13);
    for (int i = 0; i < 4; i++) got_dlc[3 - i] = ds_q[15 + i];
    chk("dlc12_field", 64'(got_dlc), 64'hC);
    chk("dlc12_destuffed_len", 64'(ds_q.size()), 64'd98);

    // DV pulsed mid-frame with different contents must be ignored.
    send_frame(11'($urandom_range(0, 2047)), 4'd8, {$urandom, $urandom});
    repeat (200) @(negedge clk);
    drive(11'h5A5, 4'd3, {$urandom, $urandom});
    @(negedge clk);
    tx.i_Tx_DV = 1'b0;
    tx.i_Tx_Id = 11'h0F0;
    wait_done();
    repeat (5) @(negedge clk);
    chk("dv_ignored_active", 64'(tx.o_Tx_Active), 64'd0);

    // DV held high through Done: second SOF on the clock after the pulse.
    wait_idle();
    drive(11'h2AA, 4'd2, 64'hA5C3_0000_0000_0000);
    push_frame(11'h2AA, 4'd2, 64'hA5C3_0000_0000_0000);
    push_frame(11'h2AA, 4'd2, 64'hA5C3_0000_0000_0000);
    wait_done();
    @(negedge clk);
    chk("b2b_active", 64'(tx.o_Tx_Active), 64'd1);
    chk("b2b_sof", 64'(tx.o_Tx_Serial), 64'd0);
    tx.i_Tx_DV = 1'b0;
    wait_done();

    // Reset during the data field.
    send_frame(11'h3C1, 4'd8, {$urandom, $urandom});
    ok = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      if (tx.dbg_state == ST_DATA) begin
        ok = 1'b1;
        break;
      end
    end
    chk("reach_data_state", 64'(ok), 64'd1);
    repeat (20) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_mid_serial", 64'(tx.o_Tx_Serial), 64'd1);
    chk("rst_mid_active", 64'(tx.o_Tx_Active), 64'd0);
    chk("rst_mid_done",   64'(tx.o_Tx_Done),   64'd0);
    exp_q.delete();
    len_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_done",   64'(tx.o_Tx_Done),   64'd0);
    chk("post_rst_active", 64'(tx.o_Tx_Active), 64'd0);
    send_frame(11'h456, 4'd5, PAYLOAD);
    wait_done();

    // Random frames.
    for (int n = 0; n < 6; n++) begin
      send_frame(11'($urandom_range(0, 2047)), 4'($urandom_range(0, 15)), {$urandom, $urandom});
      wait_done();
    end

    repeat (5) @(negedge clk);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    chk("len_q_drained", 64'(len_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
